pdm_mic_frontend: RTL and testbench
===================================

Name: pdm_mic_frontend

Overview:
- Upstream stage of the recorder. Generates the clock for a PDM MEMS microphone and captures its 1-bit data stream.
- Decimates the stream with a box-car (ones-count) filter into signed 8-bit PCM samples.
- Emits a single-cycle valid strobe per sample. audio_out/audio_valid_out connect directly to the recorder's audio_in/audio_valid_in.
- Default rates: 98.304 MHz system clock, 3.072 MHz mic clock, 48 kHz samples.

Parameters:
CLK_DIV, 32, system clocks per mic-clock period; even, 4..1024
DECIM, 64, captured PDM bits per output sample; power of two, 2..256

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-low
enable_in  input  1  run mic clock and capture; low = idle
pdm_in  input  1  raw PDM data from microphone (asynchronous to clk_in)
mic_clk_out  output  1  clock to microphone, 50% duty, clk_in/CLK_DIV
audio_out  output  8  signed PCM sample, held between strobes
audio_valid_out  output  1  one-cycle strobe, audio_out new this cycle
clip_out  output  1  sticky: set when a sample saturated; cleared by reset or enable_in low

Behaviour:
- Reset (rst_in=0, asynchronous): div_cnt=0, bit_cnt=0, ones_cnt=0, mic_clk_out=0, audio_out=0, audio_valid_out=0, clip_out=0, synchronizer flops=0. Release is applied synchronously inside the block via the first clock edge; no output glitches.
- Divider: div_cnt counts 0..CLK_DIV-1 while enable_in=1, then wraps.
  - mic_clk_out is registered: 0 when div_cnt < CLK_DIV/2, else 1.
  - enable_in=0: div_cnt, bit_cnt and ones_cnt clear to 0, mic_clk_out is forced 0, no strobes, clip_out clears, audio_out holds its last value.
- Input path: pdm_in passes through a 2-FF synchronizer (pdm_s).
- Capture: on the cycle div_cnt==CLK_DIV-1 (end of the high phase), capture pdm_s.
  - ones_cnt += pdm_s; bit_cnt increments.
  - ones_cnt width is log2(DECIM)+1, so it holds 0..DECIM.
- Sample formation: on the capture cycle where bit_cnt==DECIM-1:
  - total = ones_cnt + pdm_s, range 0..DECIM.
  - SH = 8 - log2(DECIM); value = (total << SH) - 128, computed in 10-bit signed.
  - value > 127 → audio_out=127, clip_out=1. total=0 gives -128 exactly, which is not a clip.
  - audio_out is registered, audio_valid_out=1 for exactly the next cycle, ones_cnt and bit_cnt restart at 0.
  - Latency: strobe is 1 clk_in cycle after the final capture.
- Strobe period: exactly CLK_DIV*DECIM clk_in cycles in steady state.
  - First strobe after enable_in rises: CLK_DIV*DECIM cycles after the first divider count, plus 1.
- enable_in deasserted mid-window: the partial window is discarded and no strobe is produced. Re-enable starts a fresh window with div_cnt=0.
- Reset mid-window: everything returns to reset values immediately. audio_out goes to 0.
- enable_in toggling on the same cycle as a capture: enable_in=0 has priority; the capture is dropped.
- audio_valid_out is never high on two consecutive cycles.

Decomposition:
- Shared package audio_pkg holds:
  - typedef sample_t (logic signed [7:0])
  - constants SAMPLE_MAX=127, SAMPLE_MIN=-128, SYS_CLK_HZ=98_304_000
- One sub-module, sync_2ff: a generic 2-flop synchronizer with async active-low reset, reused for other asynchronous inputs.
- Divider and decimator stay in the top module.

Test Plan:
- Bench parameters throughout: CLK_DIV=4, DECIM=8, so SH=5.
- Reset, enable_in=1, pdm_in constant 1 → mic_clk_out period 4 clk, 50% duty; first audio_valid_out at cycle 33 after enable; audio_out=127; clip_out=1; strobes every 32 cycles.
- pdm_in constant 0 → audio_out=-128 each strobe; clip_out stays 0.
- pdm_in alternating 1,0 per mic clock → audio_out=0; with pattern 3 ones of every 4 → total=6 → audio_out=64.
- Drop enable_in after 5 captures, re-raise → no strobe for the partial window; next strobe 33 cycles after re-enable; mic_clk_out held 0 while disabled; clip_out cleared.
- Assert rst_in=0 asynchronously mid-window (between clock edges) → all outputs 0 immediately, before the next edge; after release, timing matches the first scenario.
- Random pdm_in for 1000 samples vs reference model → every audio_out equals saturate((ones<<5)-128); strobe spacing always 32 cycles.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio types and constants for the recorder datapath.
// Also holds the PCM saturation helper used by the mic front end.
package audio_pkg;

    typedef logic signed [7:0] sample_t;

    localparam sample_t SAMPLE_MAX = 8'sd127;
    localparam sample_t SAMPLE_MIN = 8'sh80;
    localparam int      SYS_CLK_HZ = 98_304_000;

    function automatic sample_t sat_sample(input logic signed [9:0] v);
        sample_t r;
        if (v > 10'sd127) begin
            r = SAMPLE_MAX;
        end else if (v < -10'sd128) begin
            r = SAMPLE_MIN;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs.
// Async active-low reset clears both stages to zero.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_in;
            r_sync <= r_meta;
        end
    end

    assign q_out = r_sync;

endmodule

// File: rtl/pdm_mic_frontend.sv
// PDM microphone front end: mic clock divider, bit capture and
// box-car decimation into signed 8-bit PCM with a one-cycle strobe.
module pdm_mic_frontend
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 32,
    parameter int DECIM   = 64
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    enable_in,
    input  logic    pdm_in,
    output logic    mic_clk_out,
    output sample_t audio_out,
    output logic    audio_valid_out,
    output logic    clip_out
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int LOG2D  = $clog2(DECIM);
    localparam int ONES_W = LOG2D + 1;
    localparam int SH     = 8 - LOG2D;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [LOG2D-1:0] BIT_LAST = LOG2D'(DECIM - 1);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [LOG2D-1:0]  r_bit_cnt;
    logic [ONES_W-1:0] r_ones_cnt;
    logic              r_mic_clk;
    sample_t           r_audio;
    logic              r_valid;
    logic              r_clip;

    logic              w_pdm_s;
    logic              w_div_wrap;
    logic [DIV_W-1:0]  w_div_nxt;
    logic              w_last_bit;
    logic [ONES_W-1:0] w_total;
    logic [9:0]        w_shift;
    logic signed [9:0] w_value;
    sample_t           w_sample;
    logic              w_clip;

    sync_2ff #(
        .WIDTH (1)
    ) u_pdm_sync (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (pdm_in),
        .q_out  (w_pdm_s)
    );

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_div_nxt  = w_div_wrap ? '0 : r_div_cnt + 1'b1;
    assign w_last_bit = (r_bit_cnt == BIT_LAST);

    // Full-scale window (all ones) maps to +128, one past SAMPLE_MAX.
    assign w_total  = r_ones_cnt + ONES_W'(w_pdm_s);
    assign w_shift  = 10'(w_total) << SH;
    assign w_value  = $signed(w_shift) - 10'sd128;
    assign w_sample = sat_sample(w_value);
    assign w_clip   = (w_value > 10'sd127);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_mic_clk  <= 1'b0;
            r_audio    <= '0;
            r_valid    <= 1'b0;
            r_clip     <= 1'b0;
        end else if (!enable_in) begin
            // Disable wins over any capture due this cycle.
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
            r_mic_clk  <= 1'b0;
            r_valid    <= 1'b0;
            r_clip     <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_mic_clk <= (w_div_nxt >= DIV_HALF);
            r_valid   <= 1'b0;
            if (w_div_wrap) begin
                if (w_last_bit) begin
                    r_audio    <= w_sample;
                    r_valid    <= 1'b1;
                    r_clip     <= r_clip | w_clip;
                    r_bit_cnt  <= '0;
                    r_ones_cnt <= '0;
                end else begin
                    r_bit_cnt  <= r_bit_cnt + 1'b1;
                    r_ones_cnt <= w_total;
                end
            end
        end
    end

    assign mic_clk_out     = r_mic_clk;
    assign audio_out       = r_audio;
    assign audio_valid_out = r_valid;
    assign clip_out        = r_clip;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Self-checking bench for pdm_mic_frontend at CLK_DIV=4, DECIM=8.
// Expected samples come from ones counts of the driven bit stream.
module tb_pdm_mic_frontend;

    logic              clk_in = 1'b0;
    logic              rst_in = 1'b0;
    logic              enable_in = 1'b0;
    logic              pdm_in = 1'b0;
    logic              mic_clk_out;
    logic signed [7:0] audio_out;
    logic              audio_valid_out;
    logic              clip_out;

    int checks = 0;
    int failures = 0;

    // Edges since the current run started, and ones in the open window.
    int e = 0;
    int acc = 0;
    logic signed [7:0] exp_audio = '0;
    logic exp_clip = 1'b0;

    always #5 clk_in = ~clk_in;

    pdm_mic_frontend #(
        .CLK_DIV (4),
        .DECIM   (8)
    ) u_dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .pdm_in          (pdm_in),
        .mic_clk_out     (mic_clk_out),
        .audio_out       (audio_out),
        .audio_valid_out (audio_valid_out),
        .clip_out        (clip_out)
    );

    function automatic logic signed [7:0] model_pcm(input int ones);
        int v;
        v = ones * 32 - 128;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic gen_bit(input int mode, input int k);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (k % 2) == 0;
            3: return (k % 4) != 3;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // One clock of the reference model: 4-cycle mic clock low then high,
    // a sample every 32 cycles from the ones seen in that window.
    task automatic tick(output logic ev, output logic em);
        @(posedge clk_in);
        #1;
        e++;
        em = (e % 4) >= 2;
        ev = (e % 32) == 0;
        if (ev) begin
            exp_audio = model_pcm(acc);
            if (acc * 32 - 128 > 127) exp_clip = 1'b1;
            acc = 0;
        end
    endtask

    task automatic start_run();
        enable_in = 1'b1;
        e = 0;
        acc = 0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        enable_in = 1'b0;
        pdm_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checks += 4;
        if (mic_clk_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mic got=%b exp=0", mic_clk_out);
        end
        if (audio_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", audio_valid_out);
        end
        if (audio_out !== 8'sd0) begin
            failures++;
            $display("FAIL reset_audio got=%0d exp=0", audio_out);
        end
        if (clip_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_clip got=%b exp=0", clip_out);
        end
        rst_in = 1'b1;
        repeat (2) begin
            @(posedge clk_in);
            #1;
            checks += 2;
            if (mic_clk_out !== 1'b0) begin
                failures++;
                $display("FAIL idle_mic got=%b exp=0", mic_clk_out);
            end
            if (audio_valid_out !== 1'b0) begin
                failures++;
                $display("FAIL idle_valid got=%b exp=0", audio_valid_out);
            end
        end
    endtask

    task automatic test_idle(input int n);
        enable_in = 1'b0;
        exp_clip = 1'b0;
        repeat (n) begin
            @(posedge clk_in);
            #1;
            checks += 4;
            if (mic_clk_out !== 1'b0) begin
                failures++;
                $display("FAIL idle_mic got=%b exp=0", mic_clk_out);
            end
            if (audio_valid_out !== 1'b0) begin
                failures++;
                $display("FAIL idle_valid got=%b exp=0", audio_valid_out);
            end
            if (clip_out !== 1'b0) begin
                failures++;
                $display("FAIL idle_clip got=%b exp=0", clip_out);
            end
            if (audio_out !== exp_audio) begin
                failures++;
                $display("FAIL idle_hold got=%0d exp=%0d", audio_out, exp_audio);
            end
        end
    endtask

    task automatic test_const_one();
        logic ev, em;
        start_run();
        for (int k = 0; k < 24; k++) begin
            pdm_in = 1'b1;
            acc++;
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 4;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL one_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (mic_clk_out !== em) begin
                    failures++;
                    $display("FAIL one_mic cyc=%0d got=%b exp=%b", e + 1, mic_clk_out, em);
                end
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL one_audio cyc=%0d got=%0d exp=%0d", e + 1, audio_out, exp_audio);
                end
                if (clip_out !== exp_clip) begin
                    failures++;
                    $display("FAIL one_clip cyc=%0d got=%b exp=%b", e + 1, clip_out, exp_clip);
                end
            end
        end
    endtask

    task automatic test_const_zero();
        logic ev, em;
        test_idle(3);
        start_run();
        for (int k = 0; k < 16; k++) begin
            pdm_in = 1'b0;
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 3;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL zero_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL zero_audio cyc=%0d got=%0d exp=%0d", e + 1, audio_out, exp_audio);
                end
                if (clip_out !== exp_clip) begin
                    failures++;
                    $display("FAIL zero_clip cyc=%0d got=%b exp=%b", e + 1, clip_out, exp_clip);
                end
            end
        end
    endtask

    task automatic test_patterns();
        logic ev, em;
        for (int k = 0; k < 32; k++) begin
            pdm_in = gen_bit(k < 16 ? 2 : 3, k);
            acc += int'(pdm_in);
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 3;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL pat_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL pat_audio cyc=%0d got=%0d exp=%0d", e + 1, audio_out, exp_audio);
                end
                if (mic_clk_out !== em) begin
                    failures++;
                    $display("FAIL pat_mic cyc=%0d got=%b exp=%b", e + 1, mic_clk_out, em);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic ev, em;
        test_idle(2);
        start_run();
        for (int k = 0; k < 13; k++) begin
            pdm_in = 1'b1;
            acc++;
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 2;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL drop_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (clip_out !== exp_clip) begin
                    failures++;
                    $display("FAIL drop_clip cyc=%0d got=%b exp=%b", e + 1, clip_out, exp_clip);
                end
            end
        end
        test_idle(6);
        start_run();
        for (int k = 0; k < 16; k++) begin
            pdm_in = gen_bit(3, k);
            acc += int'(pdm_in);
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 3;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL reen_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL reen_audio cyc=%0d got=%0d exp=%0d", e + 1, audio_out, exp_audio);
                end
                if (clip_out !== exp_clip) begin
                    failures++;
                    $display("FAIL reen_clip cyc=%0d got=%b exp=%b", e + 1, clip_out, exp_clip);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic ev, em;
        for (int k = 0; k < 8; k++) begin
            pdm_in = 1'b1;
            acc++;
            repeat (4) tick(ev, em);
        end
        pdm_in = 1'b1;
        acc++;
        repeat (2) tick(ev, em);
        checks += 3;
        if (mic_clk_out !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_mic got=%b exp=1", mic_clk_out);
        end
        if (audio_out !== 8'sd127) begin
            failures++;
            $display("FAIL pre_rst_audio got=%0d exp=127", audio_out);
        end
        if (clip_out !== 1'b1) begin
            failures++;
            $display("FAIL pre_rst_clip got=%b exp=1", clip_out);
        end
        #2;
        rst_in = 1'b0;
        #1;
        checks += 4;
        if (mic_clk_out !== 1'b0) begin
            failures++;
            $display("FAIL arst_mic got=%b exp=0", mic_clk_out);
        end
        if (audio_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL arst_valid got=%b exp=0", audio_valid_out);
        end
        if (audio_out !== 8'sd0) begin
            failures++;
            $display("FAIL arst_audio got=%0d exp=0", audio_out);
        end
        if (clip_out !== 1'b0) begin
            failures++;
            $display("FAIL arst_clip got=%b exp=0", clip_out);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        exp_audio = '0;
        exp_clip = 1'b0;
        e = 0;
        acc = 0;
        for (int k = 0; k < 24; k++) begin
            pdm_in = 1'b1;
            acc++;
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 4;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL post_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (mic_clk_out !== em) begin
                    failures++;
                    $display("FAIL post_mic cyc=%0d got=%b exp=%b", e + 1, mic_clk_out, em);
                end
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL post_audio cyc=%0d got=%0d exp=%0d", e + 1, audio_out, exp_audio);
                end
                if (clip_out !== exp_clip) begin
                    failures++;
                    $display("FAIL post_clip cyc=%0d got=%b exp=%b", e + 1, clip_out, exp_clip);
                end
            end
        end
    endtask

    task automatic test_random();
        logic ev, em;
        int last;
        last = -1;
        for (int k = 0; k < 8000; k++) begin
            pdm_in = gen_bit(4, k);
            acc += int'(pdm_in);
            for (int c = 0; c < 4; c++) begin
                tick(ev, em);
                checks += 4;
                if (audio_valid_out !== ev) begin
                    failures++;
                    $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", e + 1, audio_valid_out, ev);
                end
                if (audio_out !== exp_audio) begin
                    failures++;
                    $display("FAIL rnd_audio cyc=%0d got=%0d exp=%0d", e + 1, audio_out, exp_audio);
                end
                if (clip_out !== exp_clip) begin
                    failures++;
                    $display("FAIL rnd_clip cyc=%0d got=%b exp=%b", e + 1, clip_out, exp_clip);
                end
                if (mic_clk_out !== em) begin
                    failures++;
                    $display("FAIL rnd_mic cyc=%0d got=%b exp=%b", e + 1, mic_clk_out, em);
                end
                if (audio_valid_out === 1'b1) begin
                    if (last >= 0) begin
                        checks++;
                        if (e - last !== 32) begin
                            failures++;
                            $display("FAIL rnd_spacing cyc=%0d got=%0d exp=32", e + 1, e - last);
                        end
                    end
                    last = e;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_one();
        test_const_zero();
        test_patterns();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
